// File: rtl/mole_game_controller.sv
// Round sequencer for the mole generator: shows moles, scores hits against the
// live mask, tracks lives and shortens the show window as rounds are cleared.
module mole_game_controller #(
  parameter int NUM_HOLES     = 18,
  parameter int SHOW_INIT     = 50_000_000,
  parameter int SHOW_MIN      = 10_000_000,
  parameter int SHOW_STEP     = 5_000_000,
  parameter int SPEEDUP_EVERY = 4,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int LIVES_INIT    = 3,
  parameter int SCORE_W       = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hits,
  input  logic [NUM_HOLES-1:0] mole_positions,
  output logic                 mole_clk,
  output logic [NUM_HOLES-1:0] live_mask,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           lives,
  output logic                 playing,
  output logic                 game_over
);

  localparam int MAX_LEN = (SHOW_INIT > GAP_CYCLES) ? SHOW_INIT : GAP_CYCLES;
  localparam int TIMER_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = $clog2(SPEEDUP_EVERY + 1);
  localparam int HC_W    = $clog2(NUM_HOLES + 1);
  localparam int SUM_W   = ((SCORE_W > HC_W) ? SCORE_W : HC_W) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SHOW, S_GAP, S_OVER} state_e;

  state_e               state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [TIMER_W-1:0]   show_len_q;
  logic [CNT_W-1:0]     clr_cnt_q;
  logic                 mole_clk_q;
  logic [NUM_HOLES-1:0] live_mask_q;
  logic [SCORE_W-1:0]   score_q;
  logic [2:0]           lives_q;
  logic                 playing_q;
  logic                 game_over_q;

  logic [NUM_HOLES-1:0] hit_live;
  logic [NUM_HOLES-1:0] mask_left_d;
  logic [HC_W-1:0]      hit_cnt;
  logic [SUM_W-1:0]     score_sum;
  logic [SCORE_W-1:0]   score_d;
  logic [2:0]           lives_d;
  logic [TIMER_W-1:0]   show_len_d;

  always_comb begin
    hit_live    = hits & live_mask_q;
    mask_left_d = live_mask_q & ~hits;
    hit_cnt     = '0;
    for (int i = 0; i < NUM_HOLES; i++) hit_cnt = hit_cnt + HC_W'(hit_live[i]);
    score_sum = SUM_W'(score_q) + SUM_W'(hit_cnt);
    score_d   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    lives_d   = lives_q - 3'd1;
    // Compare before subtracting so the window never wraps below the floor.
    if (int'(show_len_q) >= SHOW_MIN + SHOW_STEP) show_len_d = show_len_q - TIMER_W'(SHOW_STEP);
    else                                          show_len_d = TIMER_W'(SHOW_MIN);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it sits inside the clocked branch rather than the sensitivity list.
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      show_len_q  <= TIMER_W'(SHOW_INIT);
      clr_cnt_q   <= '0;
      mole_clk_q  <= 1'b0;
      live_mask_q <= '0;
      score_q     <= '0;
      lives_q     <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            score_q     <= '0;
            lives_q     <= 3'(LIVES_INIT);
            show_len_q  <= TIMER_W'(SHOW_INIT);
            clr_cnt_q   <= '0;
            mole_clk_q  <= 1'b1;
            timer_q     <= TIMER_W'(1);
            playing_q   <= 1'b1;
            game_over_q <= 1'b0;
            state_q     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (timer_q == '0) begin
            live_mask_q <= mole_positions;
            timer_q     <= show_len_q - TIMER_W'(1);
            state_q     <= S_SHOW;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end
        S_SHOW: begin
          score_q     <= score_d;
          live_mask_q <= mask_left_d;
          timer_q     <= timer_q - TIMER_W'(1);
          if (mask_left_d == '0 || timer_q == '0) begin
            mole_clk_q  <= 1'b0;
            live_mask_q <= '0;
            timer_q     <= TIMER_W'(GAP_CYCLES - 1);
            state_q     <= S_GAP;
            // A clear wins over a simultaneous timeout.
            if (mask_left_d == '0) begin
              if (clr_cnt_q == CNT_W'(SPEEDUP_EVERY - 1)) begin
                clr_cnt_q  <= '0;
                show_len_q <= show_len_d;
              end else begin
                clr_cnt_q <= clr_cnt_q + CNT_W'(1);
              end
            end else begin
              lives_q <= lives_d;
              if (lives_d == 3'd0) begin
                state_q     <= S_OVER;
                playing_q   <= 1'b0;
                game_over_q <= 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          if (timer_q == '0) begin
            mole_clk_q <= 1'b1;
            timer_q    <= TIMER_W'(1);
            state_q    <= S_SETTLE;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mole_clk  = mole_clk_q;
  assign live_mask = live_mask_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_game_controller.sv
// Directed bench for mole_game_controller: rounds, misses, speed-up floor,
// score saturation, game over, clear-on-timeout and mid-round reset.
module tb_mole_game_controller;

  localparam int NH = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NH-1:0] hits;
  logic [NH-1:0] mole_positions;
  logic          mole_clk;
  logic [NH-1:0] live_mask;
  logic [3:0]    score;
  logic [2:0]    lives;
  logic          playing;
  logic          game_over;

  int n_checks = 0;
  int n_errors = 0;

  mole_game_controller #(
    .NUM_HOLES(NH), .SHOW_INIT(20), .SHOW_MIN(8), .SHOW_STEP(8),
    .SPEEDUP_EVERY(2), .GAP_CYCLES(4), .LIVES_INIT(3), .SCORE_W(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hits(hits),
    .mole_positions(mole_positions), .mole_clk(mole_clk), .live_mask(live_mask),
    .score(score), .lives(lives), .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From a SHOW-exit edge: 4 GAP cycles plus 2 SETTLE cycles to the next SHOW.
  task automatic gap_settle();
    repeat (6) tick();
  endtask

  // Clear the 18'h00025 round with one triple hit.
  task automatic clear_round(input string tag, input logic [3:0] exp_score);
    hits = 18'h00025;
    tick();
    hits = '0;
    check({tag, "_score"}, 32'(score), 32'(exp_score));
    check({tag, "_mclk"}, 32'(mole_clk), 32'd0);
    check({tag, "_lives"}, 32'(lives), 32'(lives));
    gap_settle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hits = '0; mole_positions = 18'h00025;
    tick(); tick();
    check("rst_mclk", 32'(mole_clk), 32'd0);
    check("rst_mask", 32'(live_mask), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_lives", 32'(lives), 32'd0);
    check("rst_play", 32'(playing), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    reset = 1'b0;
    tick();

    // Start: mole_clk up next cycle, mask two cycles later.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_mclk", 32'(mole_clk), 32'd1);
    check("start_play", 32'(playing), 32'd1);
    check("start_lives", 32'(lives), 32'd3);
    check("start_score", 32'(score), 32'd0);
    tick();
    check("settle_mask", 32'(live_mask), 32'd0);
    tick();
    check("show_mask", 32'(live_mask), 32'h25);

    // Full clear with two separate hits.
    hits = 18'h00001;
    tick();
    hits = '0;
    check("hit1_score", 32'(score), 32'd1);
    check("hit1_mask", 32'(live_mask), 32'h24);
    tick();
    hits = 18'h00024;
    tick();
    hits = '0;
    check("clr_score", 32'(score), 32'd3);
    check("clr_lives", 32'(lives), 32'd3);
    check("clr_mask", 32'(live_mask), 32'd0);
    check("clr_mclk", 32'(mole_clk), 32'd0);
    repeat (3) tick();
    check("gap_mclk_low", 32'(mole_clk), 32'd0);
    tick();
    check("gap_mclk_rise", 32'(mole_clk), 32'd1);
    tick(); tick();
    check("r2_mask", 32'(live_mask), 32'h25);

    // Miss round of 20 cycles; empty-hole hit ignored.
    hits = 18'h00002;
    tick();
    hits = '0;
    check("empty_score", 32'(score), 32'd3);
    check("empty_mask", 32'(live_mask), 32'h25);
    repeat (18) tick();
    check("miss19_mclk", 32'(mole_clk), 32'd1);
    check("miss19_lives", 32'(lives), 32'd3);
    tick();
    check("miss_lives", 32'(lives), 32'd2);
    check("miss_mclk", 32'(mole_clk), 32'd0);
    check("miss_mask", 32'(live_mask), 32'd0);
    gap_settle();

    // Second clear of the game triggers the speed-up to 12.
    clear_round("clr2", 4'd6);
    repeat (11) tick();
    check("len12_pre_mclk", 32'(mole_clk), 32'd1);
    check("len12_pre_lives", 32'(lives), 32'd2);
    tick();
    check("len12_mclk", 32'(mole_clk), 32'd0);
    check("len12_lives", 32'(lives), 32'd1);
    gap_settle();

    // Four clears: two speed-ups land on the floor of 8; score saturates.
    clear_round("clr3", 4'd9);
    clear_round("clr4", 4'd12);
    clear_round("clr5", 4'd15);
    clear_round("clr6_sat", 4'd15);
    repeat (7) tick();
    check("len8_pre_mclk", 32'(mole_clk), 32'd1);
    check("len8_pre_over", 32'(game_over), 32'd0);
    tick();
    check("over_flag", 32'(game_over), 32'd1);
    check("over_play", 32'(playing), 32'd0);
    check("over_mclk", 32'(mole_clk), 32'd0);
    check("over_lives", 32'(lives), 32'd0);
    repeat (5) tick();
    check("over_score_held", 32'(score), 32'd15);
    check("over_mclk_held", 32'(mole_clk), 32'd0);

    // Restart from OVER.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("re_score", 32'(score), 32'd0);
    check("re_lives", 32'(lives), 32'd3);
    check("re_mclk", 32'(mole_clk), 32'd1);
    check("re_over", 32'(game_over), 32'd0);
    tick(); tick();
    check("re_mask", 32'(live_mask), 32'h25);

    // Last hit on the timeout cycle counts as a clear (window back at 20).
    hits = 18'h00001;
    tick();
    hits = '0;
    repeat (18) tick();
    check("edge_pre_mclk", 32'(mole_clk), 32'd1);
    start = 1'b1;
    hits = 18'h00024;
    tick();
    hits = '0;
    start = 1'b0;
    check("edge_lives", 32'(lives), 32'd3);
    check("edge_score", 32'(score), 32'd3);
    check("edge_mclk", 32'(mole_clk), 32'd0);
    check("edge_play", 32'(playing), 32'd1);
    gap_settle();
    check("r_mask", 32'(live_mask), 32'h25);

    // Reset mid-SHOW.
    hits = 18'h00004;
    tick();
    hits = '0;
    check("pre_rst_score", 32'(score), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_mclk", 32'(mole_clk), 32'd0);
    check("mid_rst_mask", 32'(live_mask), 32'd0);
    check("mid_rst_score", 32'(score), 32'd0);
    check("mid_rst_lives", 32'(lives), 32'd0);
    check("mid_rst_play", 32'(playing), 32'd0);
    check("mid_rst_over", 32'(game_over), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
